// File: rtl/can_tx_scheduler.sv
// Transmit mailbox scheduler: presents the lowest-ID pending mailbox to one CAN node and tracks retries.
// Optional build macro CAN_SCHED_STATS_EN adds tx_total/retx_total saturating counters.
package can_tx_pkg;
  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned ID_SIZE   = 11;
endpackage

module can_tx_scheduler
  import can_tx_pkg::*;
#(
  parameter int unsigned NUM_MBOX  = 4,
  parameter int unsigned MAX_RETRY = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_MBOX)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ID_SIZE-1:0]   wr_id,
  output logic                 wr_err,
  input  logic [NUM_MBOX-1:0]  abort,
  input  logic                 node_req,
  input  logic                 node_retx,
  output logic [DATA_SIZE-1:0] node_packet,
  output logic [ID_SIZE-1:0]   node_id,
  output logic [NUM_MBOX-1:0]  pending,
  output logic                 busy,
  output logic [NUM_MBOX-1:0]  done,
  output logic [NUM_MBOX-1:0]  fail
`ifdef CAN_SCHED_STATS_EN
  ,
  output logic [15:0]          tx_total,
  output logic [15:0]          retx_total
`endif
);

  localparam int unsigned RETRY_W = 8;
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  typedef enum logic {IDLE, INFLIGHT} state_t;

  state_t               state_q, state_d;
  logic [NUM_MBOX-1:0]  valid_q, valid_d;
  logic [IDX_W-1:0]     infl_q, infl_d;
  logic [IDX_W-1:0]     cand_idx_q, cand_idx_d;
  logic                 cand_vld_q, cand_vld_d;
  logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
  logic                 retx_q, retx_rise;
  logic                 wr_ok, wr_err_d, req_idle;
  logic [NUM_MBOX-1:0]  done_d, fail_d;
  logic [DATA_SIZE-1:0] packet_d;
  logic [ID_SIZE-1:0]   nid_d, id_eff, best_id;
  logic [DATA_SIZE-1:0] data_q [NUM_MBOX];
  logic [ID_SIZE-1:0]   id_q   [NUM_MBOX];

  // Next-state: retry/retire/commit, then abort and write, then candidate selection on the updated set
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    infl_d    = infl_q;
    retry_d   = retry_q;
    done_d    = '0;
    fail_d    = '0;
    req_idle  = 1'b0;
    retx_rise = node_retx & ~retx_q;
    retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

    case (state_q)
      IDLE: req_idle = node_req;
      INFLIGHT: begin
        if (retx_rise) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_LIM) begin
            fail_d[infl_q]  = 1'b1;
            valid_d[infl_q] = 1'b0;
            retry_d         = '0;
            state_d         = IDLE;
            req_idle        = node_req;
          end
        end else if (node_req && !node_retx) begin
          done_d[infl_q]  = 1'b1;
          valid_d[infl_q] = 1'b0;
          state_d         = IDLE;
          req_idle        = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (req_idle && cand_vld_q) begin
      state_d = INFLIGHT;
      infl_d  = cand_idx_q;
      retry_d = '0;
    end

    // The in-flight message and the one the node is latching right now are protected
    for (int unsigned i = 0; i < NUM_MBOX; i++) begin
      if (abort[i] && !(state_q == INFLIGHT && IDX_W'(i) == infl_q) &&
          !(node_req && cand_vld_q && IDX_W'(i) == cand_idx_q))
        valid_d[i] = 1'b0;
    end

    wr_ok = wr_en && (32'(wr_idx) < NUM_MBOX) && (wr_data != '0) &&
            !(state_q == INFLIGHT && wr_idx == infl_q) &&
            !(node_req && cand_vld_q && wr_idx == cand_idx_q);
    wr_err_d = wr_en && !wr_ok;
    if (wr_ok) valid_d[wr_idx] = 1'b1;

    cand_vld_d = 1'b0;
    cand_idx_d = cand_idx_q;
    best_id    = '0;
    id_eff     = '0;
    for (int unsigned i = 0; i < NUM_MBOX; i++) begin
      id_eff = (wr_ok && wr_idx == IDX_W'(i)) ? wr_id : id_q[i];
      if (valid_d[i] && !(state_d == INFLIGHT && IDX_W'(i) == infl_d) &&
          (!cand_vld_d || id_eff < best_id)) begin
        cand_vld_d = 1'b1;
        cand_idx_d = IDX_W'(i);
        best_id    = id_eff;
      end
    end

    packet_d = '0;
    nid_d    = '0;
    if (cand_vld_d) begin
      packet_d = (wr_ok && wr_idx == cand_idx_d) ? wr_data : data_q[cand_idx_d];
      nid_d    = best_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      infl_q      <= '0;
      cand_idx_q  <= '0;
      cand_vld_q  <= 1'b0;
      retry_q     <= '0;
      retx_q      <= 1'b0;
      node_packet <= '0;
      node_id     <= '0;
      wr_err      <= 1'b0;
      done        <= '0;
      fail        <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      infl_q      <= infl_d;
      cand_idx_q  <= cand_idx_d;
      cand_vld_q  <= cand_vld_d;
      retry_q     <= retry_d;
      retx_q      <= node_retx;
      node_packet <= packet_d;
      node_id     <= nid_d;
      wr_err      <= wr_err_d;
      done        <= done_d;
      fail        <= fail_d;
    end
  end

  // Mailbox storage; contents are only meaningful while the valid flag is set
  always_ff @(posedge clock) begin
    if (!reset && wr_ok) begin
      data_q[wr_idx] <= wr_data;
      id_q[wr_idx]   <= wr_id;
    end
  end

  assign busy    = (state_q == INFLIGHT);
  assign pending = valid_q;

`ifdef CAN_SCHED_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_total   <= '0;
      retx_total <= '0;
    end else begin
      if (|done_d && tx_total != '1) tx_total <= tx_total + 16'd1;
      if (retx_rise && retx_total != '1) retx_total <= retx_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios plus randomized traffic vs a behavioural model.
module tb_can_tx_scheduler;
  import can_tx_pkg::*;

  localparam int NMB  = 4;
  localparam int MAXR = 3;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 wr_en = 1'b0;
  logic [1:0]           wr_idx = '0;
  logic [DATA_SIZE-1:0] wr_data = '0;
  logic [ID_SIZE-1:0]   wr_id = '0;
  logic                 wr_err;
  logic [NMB-1:0]       abort = '0;
  logic                 node_req = 1'b0;
  logic                 node_retx = 1'b0;
  logic [DATA_SIZE-1:0] node_packet;
  logic [ID_SIZE-1:0]   node_id;
  logic [NMB-1:0]       pending, done, fail;
  logic                 busy;
`ifdef CAN_SCHED_STATS_EN
  logic [15:0]          tx_total, retx_total;
`endif

  int n_cmp = 0;
  int n_err = 0;

  can_tx_scheduler #(.NUM_MBOX(NMB), .MAX_RETRY(MAXR)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_id(wr_id), .wr_err(wr_err), .abort(abort), .node_req(node_req),
    .node_retx(node_retx), .node_packet(node_packet), .node_id(node_id),
    .pending(pending), .busy(busy), .done(done), .fail(fail)
`ifdef CAN_SCHED_STATS_EN
    , .tx_total(tx_total), .retx_total(retx_total)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: mailbox set, in-flight slot, retry count, and the candidate the node currently sees
  bit                   m_valid [NMB];
  logic [DATA_SIZE-1:0] m_data  [NMB];
  logic [ID_SIZE-1:0]   m_id    [NMB];
  bit                   m_busy, m_prev_retx;
  int                   m_infl, m_retry, m_cand;
  logic [DATA_SIZE-1:0] e_packet;
  logic [ID_SIZE-1:0]   e_id;
  bit                   e_wr_err;
  logic [NMB-1:0]       e_done, e_fail;

  function automatic void model_reset();
    for (int i = 0; i < NMB; i++) begin m_valid[i] = 0; m_data[i] = '0; m_id[i] = '0; end
    m_busy = 0; m_prev_retx = 0; m_infl = 0; m_retry = 0; m_cand = -1;
    e_packet = '0; e_id = '0; e_wr_err = 0; e_done = '0; e_fail = '0;
  endfunction

  function automatic void model_pick();
    m_cand = -1;
    for (int i = 0; i < NMB; i++)
      if (m_valid[i] && !(m_busy && m_infl == i))
        if (m_cand < 0 || m_id[i] < m_id[m_cand]) m_cand = i;
    e_packet = (m_cand < 0) ? '0 : m_data[m_cand];
    e_id     = (m_cand < 0) ? '0 : m_id[m_cand];
  endfunction

  function automatic void model_step(bit we, int wi, logic [DATA_SIZE-1:0] wd,
                                     logic [ID_SIZE-1:0] wid, logic [NMB-1:0] ab, bit rq, bit rx);
    bit ob = m_busy;
    int oi = m_infl;
    int c  = m_cand;
    bit take = 0;
    bit ok;
    e_done = '0; e_fail = '0;
    if (!m_busy) take = rq;
    else if (rx && !m_prev_retx) begin
      m_retry = (m_retry + 1 > 255) ? 255 : m_retry + 1;
      if (m_retry == MAXR) begin
        e_fail[m_infl] = 1'b1; m_valid[m_infl] = 0; m_busy = 0; take = rq;
      end
    end else if (rq && !rx) begin
      e_done[m_infl] = 1'b1; m_valid[m_infl] = 0; m_busy = 0; take = 1;
    end
    if (take && c >= 0) begin m_busy = 1; m_infl = c; m_retry = 0; end
    for (int i = 0; i < NMB; i++)
      if (ab[i] && !(ob && oi == i) && !(rq && c == i)) m_valid[i] = 0;
    ok = we && wd != 0 && !(ob && oi == wi) && !(rq && c == wi);
    e_wr_err = we && !ok;
    if (ok) begin m_valid[wi] = 1; m_data[wi] = wd; m_id[wi] = wid; end
    m_prev_retx = rx;
    model_pick();
  endfunction

  task automatic cyc(input bit we, input int wi, input logic [DATA_SIZE-1:0] wd,
                     input logic [ID_SIZE-1:0] wid, input logic [NMB-1:0] ab, input bit rq, input bit rx);
    wr_en = we; wr_idx = 2'(wi); wr_data = wd; wr_id = wid; abort = ab; node_req = rq; node_retx = rx;
    model_step(we, wi, wd, wid, ab, rq, rx);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, '0, 0, 0);
  endtask

  task automatic do_reset();
    wr_en = 0; abort = '0; node_req = 0; node_retx = 0; reset = 1;
    @(posedge clock); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (node_packet !== '0) begin n_err++; $display("FAIL reset_packet got %h want 0", node_packet); end
    n_cmp++; if (node_id !== '0) begin n_err++; $display("FAIL reset_id got %h want 0", node_id); end
    n_cmp++; if ({pending, busy, wr_err, done, fail} !== '0) begin n_err++;
      $display("FAIL reset_flags got p=%b b=%b e=%b d=%b f=%b want all 0", pending, busy, wr_err, done, fail); end
  endtask

  task automatic test_priority();
    cyc(1, 0, 32'hAAAA_0001, 11'h020, '0, 0, 0);
    cyc(1, 1, 32'hBBBB_0002, 11'h010, '0, 0, 0);
    n_cmp++; if (node_id !== 11'h010) begin n_err++; $display("FAIL prio_id got %h want 010", node_id); end
    n_cmp++; if (node_packet !== 32'hBBBB_0002) begin n_err++; $display("FAIL prio_pkt got %h want bbbb0002", node_packet); end
    cyc(0, 0, '0, '0, '0, 1, 0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL commit_busy got %b want 1", busy); end
    n_cmp++; if (node_id !== 11'h020) begin n_err++; $display("FAIL commit_next_id got %h want 020", node_id); end
  endtask

  task automatic test_back_to_back();
    cyc(0, 0, '0, '0, '0, 1, 0);
    n_cmp++; if (done !== 4'b0010) begin n_err++; $display("FAIL b2b_done1 got %b want 0010", done); end
    n_cmp++; if (pending !== 4'b0001) begin n_err++; $display("FAIL b2b_pending got %b want 0001", pending); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
    cyc(0, 0, '0, '0, '0, 1, 0);
    n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL b2b_done0 got %b want 0001", done); end
    n_cmp++; if ({busy, node_packet} !== '0) begin n_err++; $display("FAIL b2b_empty got b=%b pkt=%h want 0", busy, node_packet); end
  endtask

  task automatic test_retry_fail();
    cyc(1, 2, 32'hC0C0_0003, 11'h005, '0, 0, 0);
    cyc(0, 0, '0, '0, '0, 1, 0);
    for (int k = 1; k <= MAXR; k++) begin
      cyc(0, 0, '0, '0, '0, 0, 1);
      if (k < MAXR) begin
        n_cmp++; if (fail !== '0) begin n_err++; $display("FAIL early_fail edge%0d got %b want 0000", k, fail); end
        cyc(0, 0, '0, '0, '0, 0, 0);
      end
    end
    n_cmp++; if (fail !== 4'b0100) begin n_err++; $display("FAIL retry_fail got %b want 0100", fail); end
    n_cmp++; if ({pending, busy, done} !== '0) begin n_err++;
      $display("FAIL retry_after got p=%b b=%b d=%b want 0", pending, busy, done); end
    idle();
    n_cmp++; if (fail !== '0) begin n_err++; $display("FAIL fail_pulse got %b want 0000", fail); end
  endtask

  task automatic test_write_reject();
    cyc(1, 1, 32'hD0D0_0004, 11'h003, '0, 0, 0);
    cyc(1, 2, 32'hE0E0_0005, 11'h004, '0, 0, 0);
    cyc(0, 0, '0, '0, '0, 1, 0);
    cyc(1, 1, 32'h1111_1111, 11'h001, '0, 0, 0);
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL rej_inflight got %b want 1", wr_err); end
    cyc(1, 3, 32'h0, 11'h001, '0, 0, 0);
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL rej_zero got %b want 1", wr_err); end
    n_cmp++; if (pending !== 4'b0110) begin n_err++; $display("FAIL rej_zero_pend got %b want 0110", pending); end
    cyc(1, 2, 32'h2222_2222, 11'h001, '0, 1, 1);
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL rej_cand got %b want 1", wr_err); end
    n_cmp++; if ({node_packet, node_id} !== {32'hE0E0_0005, 11'h004}) begin n_err++;
      $display("FAIL rej_cand_keep got %h/%h want e0e00005/004", node_packet, node_id); end
    idle();
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL err_pulse got %b want 0", wr_err); end
    cyc(0, 0, '0, '0, '0, 1, 0);
    n_cmp++; if (done !== 4'b0010) begin n_err++; $display("FAIL rej_retire got %b want 0010", done); end
    cyc(0, 0, '0, '0, '0, 1, 0);
    n_cmp++; if (done !== 4'b0100) begin n_err++; $display("FAIL rej_retire2 got %b want 0100", done); end
  endtask

  task automatic test_tie_abort();
    cyc(1, 3, 32'hF0F0_0006, 11'h007, '0, 0, 0);
    cyc(1, 2, 32'h9090_0007, 11'h007, '0, 0, 0);
    n_cmp++; if (node_packet !== 32'h9090_0007) begin n_err++; $display("FAIL tie_low_idx got %h want 90900007", node_packet); end
    cyc(0, 0, '0, '0, 4'b0100, 0, 0);
    n_cmp++; if (node_packet !== 32'hF0F0_0006) begin n_err++; $display("FAIL abort_next got %h want f0f00006", node_packet); end
    n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL abort_pend got %b want 1000", pending); end
    cyc(1, 2, 32'h9090_0007, 11'h007, '0, 0, 0);
    cyc(0, 0, '0, '0, '0, 1, 0);
    cyc(0, 0, '0, '0, 4'b0100, 0, 0);
    n_cmp++; if ({pending, busy} !== {4'b1100, 1'b1}) begin n_err++;
      $display("FAIL abort_inflight got p=%b b=%b want 1100/1", pending, busy); end
    cyc(0, 0, '0, '0, '0, 1, 0);
    n_cmp++; if (done !== 4'b0100) begin n_err++; $display("FAIL abort_retire got %b want 0100", done); end
    cyc(0, 0, '0, '0, '0, 1, 0);
  endtask

  task automatic test_reset_midflight();
    cyc(1, 0, 32'h0000_0A01, 11'h001, '0, 0, 0);
    cyc(1, 1, 32'h0000_0A02, 11'h002, '0, 0, 0);
    cyc(1, 2, 32'h0000_0A03, 11'h003, '0, 0, 0);
    cyc(0, 0, '0, '0, '0, 1, 0);
    n_cmp++; if ({pending, busy} !== {4'b0111, 1'b1}) begin n_err++;
      $display("FAIL mid_pre got p=%b b=%b want 0111/1", pending, busy); end
    do_reset();
    n_cmp++; if ({node_packet, node_id, pending, busy, wr_err, done, fail} !== '0) begin n_err++;
      $display("FAIL mid_reset got pkt=%h id=%h p=%b b=%b d=%b f=%b want 0", node_packet, node_id, pending, busy, done, fail); end
    idle();
    n_cmp++; if ({done, fail, pending} !== '0) begin n_err++;
      $display("FAIL mid_after got d=%b f=%b p=%b want 0", done, fail, pending); end
  endtask

  task automatic test_random();
    logic [NMB-1:0] ep, ab;
    logic [DATA_SIZE-1:0] wd;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int i = 0; i < NMB; i++) ab[i] = ($urandom_range(0, 19) == 0);
      wd = ($urandom_range(0, 7) == 0) ? '0 : DATA_SIZE'($urandom);
      cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, NMB - 1)), wd,
          ID_SIZE'($urandom_range(0, 7)), ab, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      for (int i = 0; i < NMB; i++) ep[i] = m_valid[i];
      n_cmp++; if ({node_packet, node_id} !== {e_packet, e_id}) begin n_err++;
        $display("FAIL rnd_present c%0d got %h/%h want %h/%h", n, node_packet, node_id, e_packet, e_id); end
      n_cmp++; if ({pending, busy} !== {ep, m_busy}) begin n_err++;
        $display("FAIL rnd_state c%0d got p=%b b=%b want p=%b b=%b", n, pending, busy, ep, m_busy); end
      n_cmp++; if ({wr_err, done, fail} !== {e_wr_err, e_done, e_fail}) begin n_err++;
        $display("FAIL rnd_pulses c%0d got e=%b d=%b f=%b want e=%b d=%b f=%b", n, wr_err, done, fail, e_wr_err, e_done, e_fail); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_back_to_back();
    test_retry_fail();
    test_write_reject();
    test_tie_abort();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Transmit mailbox scheduler in front of one CAN node.
- Holds NUM_MBOX host-loaded messages and presents the highest-priority pending one (lowest ID) on the node's packet/ID inputs.
- Commits a message on the node's data request, retires it when the node requests again with no retransmit pending, and counts retransmissions per message, aborting after MAX_RETRY.

Parameters:
- NUM_MBOX, 4, number of mailboxes (>=2). IDX_W = $clog2(NUM_MBOX), derived.
- DATA_SIZE, package value, payload width.
- ID_SIZE, package value, identifier width.
- MAX_RETRY, 8, retransmissions tolerated before a message is aborted (1..255).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  host mailbox write strobe.
- wr_idx  in  IDX_W  target mailbox.
- wr_data  in  DATA_SIZE  payload.
- wr_id  in  ID_SIZE  transmit identifier.
- wr_err  out  1  registered; write rejected.
- abort  in  NUM_MBOX  per-mailbox cancel, level, sampled each cycle.
- node_req  in  1  node data request (node's data_in_req).
- node_retx  in  1  node retransmit flag (node's Retransmit).
- node_packet  out  DATA_SIZE  payload to node (node's In_packet); 0 = nothing to send.
- node_id  out  ID_SIZE  identifier to node (node's Tx_ID).
- pending  out  NUM_MBOX  valid flags.
- busy  out  1  a message is in flight.
- done  out  NUM_MBOX  one-cycle pulse; message retired successfully.
- fail  out  NUM_MBOX  one-cycle pulse; message aborted after MAX_RETRY.

Behaviour:
- Reset: all valid flags cleared; in-flight cleared; retry counter 0; state IDLE; node_packet=0, node_id=0, wr_err=0, done=0, fail=0, busy=0.
- Candidate selection:
  - Chosen among valid mailboxes, excluding the in-flight one: lowest wr_id wins; ties go to the lowest index.
  - Registered into cand_idx/cand_vld, and node_packet/node_id are driven from that register. Latency is 1 cycle from a write or abort to the presented value.
  - When no candidate exists, node_packet=0 and node_id=0.
- Write:
  - Accepted unless any of these hold: wr_idx is in flight; wr_data==0; node_req=1 and wr_idx==cand_idx.
  - A rejected write sets wr_err=1 for one cycle and leaves the mailbox unchanged.
  - An accepted write overwrites the mailbox and sets its valid flag.
- Abort:
  - Clears the valid flag of a non-in-flight mailbox.
  - Ignored for the in-flight mailbox and for cand_idx while node_req=1.
  - Produces no done or fail pulse.
- State IDLE:
  - node_req=1 with cand_vld=1: commit cand_idx as in-flight, retry=0, go INFLIGHT.
  - node_req=1 with cand_vld=0: stay IDLE; the node sees 0 and skips.
- State INFLIGHT, busy=1:
  - Rising edge of node_retx (registered previous value) increments retry (saturating).
  - If the incremented value equals MAX_RETRY: pulse fail[inflight], clear its valid flag, go IDLE. The node's latched copy is not recalled.
  - node_req=1 and node_retx=0: pulse done[inflight] and clear its valid flag.
    - In the same cycle, if cand_vld=1, commit cand_idx (retry=0) and stay INFLIGHT.
    - Otherwise go IDLE.
  - node_req=1 and node_retx=1: ignored (no valid retire condition).
- Simultaneous events in one cycle:
  - Retire and commit together are legal (as above).
  - A fail and a node_req together: fail takes priority. The mailbox is aborted, and the request is then handled as in IDLE.
  - A write to a mailbox being retired in the same cycle is rejected.
- Reset mid-transfer: everything is dropped and no done or fail pulse is issued.

Optional Feature:
- Macro: CAN_SCHED_STATS_EN.
- When defined, adds two outputs:
  - tx_total (16 bit): successful retirements, saturating.
  - retx_total (16 bit): node_retx rising edges, saturating.
  - Both clear on reset.
- When undefined, neither port nor counters exist, and behaviour is otherwise identical.

Test Plan:
- Write mbox0 id=0x20, then mbox1 id=0x10, with payloads nonzero -> after 1 cycle node_id=0x10 with mbox1 data; node_req -> busy=1, node_id=0x20 presented next cycle.
- In flight mbox1, node_req with node_retx=0 -> done[1] pulse, pending=4'b0001, mbox0 committed in the same cycle; next node_req with no candidate -> done[0], node_packet=0, busy=0.
- MAX_RETRY=3: three node_retx rising edges while in flight -> fail[idx] on the third, pending cleared, no done pulse.
- Write to the in-flight index, a write with wr_data=0, and a write to cand_idx during node_req -> wr_err=1 each, mailbox contents unchanged.
- Equal IDs in mbox2 and mbox3 -> mbox2 is presented; abort[2] -> mbox3 presented next cycle, and abort of the in-flight index is ignored.
- Assert reset while in flight with 3 pending -> next cycle all outputs 0, pending=0, and no done or fail pulse.
